// File: rtl/uart_rx_16x.sv
// UART receiver with 16x oversampling: 5-8 data bits, optional parity, 1 or 2 stop bits.
// Latency: the word is loaded on the tick that samples the middle of the last stop bit; o_full rises on the next clock.
// Backpressure: a single holding register. A frame that completes while it is still full is dropped and flagged as overrun.
//
// Ports:
//   i_clk, i_rst        system clock, async active-high reset
//   i_brd_clk           16x baud clock (asynchronous; edges are detected after synchronisation)
//   i_rx                serial line, idle high, LSB first
//   i_data_size         00=5 .. 11=8 data bits
//   i_parity_en         parity enable
//   i_parity_odd        parity sense
//   i_stop2             two stop bits
//   i_rd_strobe         host has consumed the held word
//   o_data              held word, zero-extended above the data size
//   o_full              unread word present
//   o_parity_err        error flag for the held word
//   o_framing_err       error flag for the held word
//   o_overrun_err       error flag for the held word
//   o_busy              receiver FSM not idle
module uart_rx_16x (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_brd_clk,
    input  logic       i_rx,
    input  logic [1:0] i_data_size,
    input  logic       i_parity_en,
    input  logic       i_parity_odd,
    input  logic       i_stop2,
    input  logic       i_rd_strobe,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_parity_err,
    output logic       o_framing_err,
    output logic       o_overrun_err,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    // Synchronizers. rx resets high so that leaving reset is never read as a start bit.
    logic       r_rx_s1, r_rx_s2;
    logic       r_brd_s1, r_brd_s2, r_brd_d;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic       r_par_pend;
    logic       r_frm_pend;
    logic       r_busy;

    logic [7:0] r_data;
    logic       r_full;
    logic       r_par_err;
    logic       r_frm_err;
    logic       r_ovr_err;

    logic       w_tick;
    logic       w_rx;
    logic       w_mid;
    logic       w_last_bit;
    logic       w_done;
    logic       w_frm_now;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_brd_s1 <= 1'b0;
            r_brd_s2 <= 1'b0;
            r_brd_d  <= 1'b0;
        end else begin
            r_rx_s1  <= i_rx;
            r_rx_s2  <= r_rx_s1;
            r_brd_s1 <= i_brd_clk;
            r_brd_s2 <= r_brd_s1;
            r_brd_d  <= r_brd_s2;
        end
    end

    assign w_tick     = r_brd_s2 & ~r_brd_d;
    assign w_rx       = r_rx_s2;
    assign w_mid      = (r_cnt == 4'd15);
    assign w_last_bit = (r_bitcnt == (3'(i_data_size) + 3'd4));

    // Frame completes on the mid-sample of the final stop bit.
    assign w_done     = w_tick && w_mid &&
                        (((r_state == STOP1) && !i_stop2) || (r_state == STOP2));
    // Framing error covers a bad first stop bit (pending) or a bad final one.
    assign w_frm_now  = r_frm_pend | ~w_rx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_bitcnt   <= 3'd0;
            r_shift    <= 8'h00;
            r_par_pend <= 1'b0;
            r_frm_pend <= 1'b0;
            r_busy     <= 1'b0;
        end else if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx) begin
                        r_state <= START;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == 4'd7) begin
                        r_cnt <= 4'd0;
                        if (!w_rx) begin
                            r_state    <= DATA;
                            r_bitcnt   <= 3'd0;
                            r_shift    <= 8'h00;
                            r_par_pend <= 1'b0;
                            r_frm_pend <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DATA: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_mid) begin
                        r_shift[r_bitcnt] <= w_rx;
                        if (w_last_bit) begin
                            r_state <= i_parity_en ? PARITY : STOP1;
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_mid) begin
                        // Unused upper shift bits are zero, so reducing all 8 is safe.
                        r_par_pend <= ((^r_shift) ^ w_rx) != i_parity_odd;
                        r_state    <= STOP1;
                    end
                end
                STOP1: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_mid) begin
                        if (i_stop2) begin
                            r_frm_pend <= ~w_rx;
                            r_state    <= STOP2;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                STOP2: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_mid) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Holding register. A read in the same cycle as completion frees the slot,
    // so the new word is taken rather than counted as an overrun.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data    <= 8'h00;
            r_full    <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovr_err <= 1'b0;
        end else if (w_done) begin
            if (!r_full || i_rd_strobe) begin
                r_data    <= r_shift;
                r_par_err <= r_par_pend;
                r_frm_err <= w_frm_now;
                r_ovr_err <= 1'b0;
                r_full    <= 1'b1;
            end else begin
                r_ovr_err <= 1'b1;
            end
        end else if (i_rd_strobe && r_full) begin
            r_full    <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovr_err <= 1'b0;
        end
    end

    assign o_data        = r_data;
    assign o_full        = r_full;
    assign o_parity_err  = r_par_err;
    assign o_framing_err = r_frm_err;
    assign o_overrun_err = r_ovr_err;
    assign o_busy        = r_busy;

endmodule

// File: doc/uart_rx_16x.md
UART_RX_16X -- requirements
Module: uart_rx_16x

Interface
REQ-001 clock  input  1  system clock, all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state.
REQ-003 brd_clk  input  1  baud-rate clock from the fractional clock generator; one rising edge = one 16x oversample tick.
REQ-004 rx  input  1  serial line, idle high, LSB first.
REQ-005 data_size  input  2  00=5, 01=6, 10=7, 11=8 data bits.
REQ-006 parity_en  input  1  1 = parity bit expected after data.
REQ-007 parity_odd  input  1  1 = odd parity, 0 = even; ignored when parity_en=0.
REQ-008 stop2  input  1  1 = two stop bits expected.
REQ-009 rd_strobe  input  1  one-cycle pulse, host has consumed data.
REQ-010 data  output  8  received word, zero-extended above data_size.
REQ-011 full  output  1  holding register contains an unread word.
REQ-012 parity_err, framing_err, overrun_err  output  1 each  error flags for the held word.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 rx and brd_clk each pass through a 2-flop synchronizer; tick = one-cycle pulse on a synchronized brd_clk 0->1 transition.
REQ-015 State, sample counter (4-bit), and bit counter advance only on a tick cycle, except rd_strobe handling and reset.
REQ-016 States: IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-017 IDLE: synchronized rx low on a tick -> START, sample counter=0.
REQ-018 START: on the 8th tick (counter==7) sample rx; 0 -> DATA with counter=0 and bit counter=0; 1 -> IDLE (false start, no flags change).
REQ-019 DATA: sample rx when counter==15 (mid-bit), shift into bit position bit counter; after bit (data_size+4) sampled -> PARITY if parity_en else STOP1.
REQ-020 PARITY: sample at counter==15; parity error = (XOR of data bits XOR sampled bit) != parity_odd.
REQ-021 STOP1: sample at counter==15; rx=0 is a framing error; stop2=1 -> STOP2, else frame complete -> IDLE.
REQ-022 STOP2: sample at counter==15; rx=0 is a framing error; frame complete -> IDLE.
REQ-023 Sample counter wraps 15->0 in START/DATA/PARITY/STOP states; it does not count in IDLE.
REQ-024 Frame complete with full=0: data, parity_err, framing_err load in the same cycle; full=1 next cycle; overrun_err=0.
REQ-025 Frame complete with full=1: new word discarded, data and its flags unchanged, overrun_err=1.
REQ-026 rd_strobe with full=1: full, parity_err, framing_err, overrun_err cleared next cycle; data holds its value.
REQ-027 rd_strobe in the same cycle as frame complete: the new word loads, full stays 1, overrun_err=0.
REQ-028 rd_strobe with full=0: no effect.
REQ-029 Mode inputs (data_size, parity_en, parity_odd, stop2) are sampled continuously; changing them mid-frame is undefined and not verified.
REQ-030 Receiver re-arms in IDLE the cycle after frame completion; back-to-back frames are accepted with no idle bit.

Reset
REQ-031 On reset: state=IDLE, counters=0, data=8'h00, full=0, all error flags=0, busy=0, synchronizers=1 for rx and 0 for brd_clk.
REQ-032 Reset asserted mid-frame aborts the frame with no load; reception restarts only on a new start bit after release.

Verification
REQ-033 8N1, byte 8'hA5, brd_clk toggling every 2 clocks -> full=1 after stop bit, data=8'hA5, all errors 0.
REQ-034 7E1, data 7'h41, wrong parity bit sent -> data=8'h41, parity_err=1, framing_err=0.
REQ-035 8N2, 8'h3C, second stop bit driven low -> data=8'h3C, framing_err=1.
REQ-036 rx low for 4 ticks then high -> returns to IDLE, busy drops, full stays 0.
REQ-037 Two frames 8'h11 then 8'h22, no rd_strobe -> data=8'h11, overrun_err=1; rd_strobe -> full=0, all errors 0.
REQ-038 Reset pulse in the middle of DATA -> all outputs at reset values; the next complete 8'h5A frame is received correctly.
